// File: rtl/vga_pkg.sv
// Shared definitions for the VGA pixel engine: modes, config layout, LFSR.
package vga_pkg;

  typedef enum logic [2:0] {
    MODE_NOISE   = 3'd0,
    MODE_SOLID   = 3'd1,
    MODE_GLYPH   = 3'd2,
    MODE_BARS    = 3'd3,
    MODE_CHECKER = 3'd4,
    MODE_RSVD5   = 3'd5,
    MODE_RSVD6   = 3'd6,
    MODE_RSVD7   = 3'd7
  } mode_t;

  // Config word field positions
  localparam int CFG_MODE_LSB  = 29;
  localparam int CFG_FG_LSB    = 16;
  localparam int CFG_BG_LSB    = 4;
  localparam int CFG_SHIFT_LSB = 0;

  typedef struct packed {
    mode_t       mode;
    logic [11:0] fg;
    logic [11:0] bg;
    logic [3:0]  shift;
  } cfg_t;

  // Right-shifting Galois form of x^16+x^14+x^13+x^11+1
  localparam logic [15:0] LFSR_TAPS = 16'hB400;

  localparam cfg_t CFG_RESET = '{mode: MODE_GLYPH, fg: 12'hFFF, bg: 12'h000, shift: 4'h0};

  function automatic logic [15:0] lfsr_next(input logic [15:0] s);
    return {1'b0, s[15:1]} ^ (s[0] ? LFSR_TAPS : 16'h0000);
  endfunction

endpackage

// File: rtl/vga_timing_counter.sv
// Parametrised h/v raster counters with sync, data-enable and frame-end decode.
module vga_timing_counter
  import vga_pkg::*;
#(
  parameter int H_ACTIVE    = 640,
  parameter int H_FP        = 16,
  parameter int H_SYNC      = 96,
  parameter int H_BP        = 48,
  parameter int V_ACTIVE    = 480,
  parameter int V_FP        = 10,
  parameter int V_SYNC      = 2,
  parameter int V_BP        = 33,
  parameter bit SYNC_ACTIVE = 1'b0
) (
  input  logic       clk,
  input  logic       rst_n,
  output logic [9:0] h,
  output logic [9:0] v,
  output logic       hs,
  output logic       vs,
  output logic       de,
  output logic       frame_end
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  if (H_TOTAL > 1024 || V_TOTAL > 1024) begin : g_bad_total
    $error("vga_timing_counter: H_TOTAL and V_TOTAL must be <= 1024");
  end

  localparam logic [9:0]  H_LAST   = 10'(H_TOTAL - 1);
  localparam logic [9:0]  V_LAST   = 10'(V_TOTAL - 1);
  // 11-bit compare bounds so a range ending exactly at 1024 still decodes
  localparam logic [10:0] H_ACT    = 11'(H_ACTIVE);
  localparam logic [10:0] V_ACT    = 11'(V_ACTIVE);
  localparam logic [10:0] HS_START = 11'(H_ACTIVE + H_FP);
  localparam logic [10:0] HS_END   = 11'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [10:0] VS_START = 11'(V_ACTIVE + V_FP);
  localparam logic [10:0] VS_END   = 11'(V_ACTIVE + V_FP + V_SYNC);

  logic [10:0] hx;
  logic [10:0] vx;

  // Raster position: h wraps each line, v advances on h wrap
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      h <= '0;
      v <= '0;
    end else if (h == H_LAST) begin
      h <= '0;
      v <= (v == V_LAST) ? '0 : v + 10'd1;
    end else begin
      h <= h + 10'd1;
    end
  end

  // Sync / enable / frame-end decode straight from the counters
  always_comb begin
    hx        = {1'b0, h};
    vx        = {1'b0, v};
    hs        = (hx >= HS_START && hx < HS_END) ? SYNC_ACTIVE : ~SYNC_ACTIVE;
    vs        = (vx >= VS_START && vx < VS_END) ? SYNC_ACTIVE : ~SYNC_ACTIVE;
    de        = (hx < H_ACT) && (vx < V_ACT);
    frame_end = (h == '0) && (vx == V_ACT);
  end

endmodule

// File: rtl/vga_pixel_engine.sv
// VGA pixel engine: timing, five pixel sources, frame-synchronous config,
// 2-stage registered output with sync aligned to colour.
module vga_pixel_engine
  import vga_pkg::*;
#(
  parameter int          H_ACTIVE    = 640,
  parameter int          H_FP        = 16,
  parameter int          H_SYNC      = 96,
  parameter int          H_BP        = 48,
  parameter int          V_ACTIVE    = 480,
  parameter int          V_FP        = 10,
  parameter int          V_SYNC      = 2,
  parameter int          V_BP        = 33,
  parameter int          COLOR_BITS  = 2,
  parameter bit          SYNC_ACTIVE = 1'b0,
  parameter logic [15:0] LFSR_SEED   = 16'hACE1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [31:0]             cfg_data,
  input  logic                    cfg_valid,
  input  logic                    glyph_bit,
  output logic [9:0]              px_x,
  output logic [9:0]              px_y,
  output logic                    hs,
  output logic                    vs,
  output logic [3*COLOR_BITS-1:0] rgb,
  output logic                    de,
  output logic                    frame_end,
  output logic                    cfg_applied
);

  localparam int         CW       = 3 * COLOR_BITS;
  localparam int         BAR_W    = H_ACTIVE / 8;
  localparam logic [9:0] BAR_LAST = 10'(BAR_W - 1);

  if (COLOR_BITS < 1 || COLOR_BITS > 4) begin : g_bad_cb
    $error("vga_pixel_engine: COLOR_BITS must be 1..4");
  end
  if (LFSR_SEED == 16'h0000) begin : g_bad_seed
    $error("vga_pixel_engine: LFSR_SEED must be non-zero");
  end
  if (H_ACTIVE < 8) begin : g_bad_hact
    $error("vga_pixel_engine: H_ACTIVE must be at least 8");
  end

  // Stage 0: raster counters
  logic [9:0] h0, v0;
  logic       hs0, vs0, de0;

  vga_timing_counter #(
    .H_ACTIVE   (H_ACTIVE),
    .H_FP       (H_FP),
    .H_SYNC     (H_SYNC),
    .H_BP       (H_BP),
    .V_ACTIVE   (V_ACTIVE),
    .V_FP       (V_FP),
    .V_SYNC     (V_SYNC),
    .V_BP       (V_BP),
    .SYNC_ACTIVE(SYNC_ACTIVE)
  ) u_timing (
    .clk      (clk),
    .rst_n    (rst_n),
    .h        (h0),
    .v        (v0),
    .hs       (hs0),
    .vs       (vs0),
    .de       (de0),
    .frame_end(frame_end)
  );

  assign px_x = h0;
  assign px_y = v0;

  // Stage 1 state
  logic       hs1, vs1, de1;
  logic [9:0] x1, y1;
  logic [9:0] bar_pos;
  logic [2:0] bar_idx;
  logic [15:0] lfsr;

  // Config shadowing
  cfg_t cfg_in, cfg_pend, cfg_act;
  logic pend;

  // Colour selection
  logic [CW-1:0] col, fg_c, bg_c, bar_c;
  logic [3:0]    shift_c;

  // Field bits that are carried but not consumed at this colour depth
  logic unused_bits;
  assign unused_bits = ^{cfg_data[28], cfg_act.fg, cfg_act.bg};

  always_comb begin
    cfg_in.mode  = mode_t'(cfg_data[CFG_MODE_LSB +: 3]);
    cfg_in.fg    = cfg_data[CFG_FG_LSB +: 12];
    cfg_in.bg    = cfg_data[CFG_BG_LSB +: 12];
    cfg_in.shift = cfg_data[CFG_SHIFT_LSB +: 4];
  end

  // Stage 1: register position/sync/enable; bar index tracks h by counting, not dividing
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hs1     <= ~SYNC_ACTIVE;
      vs1     <= ~SYNC_ACTIVE;
      de1     <= 1'b0;
      x1      <= '0;
      y1      <= '0;
      bar_pos <= '0;
      bar_idx <= '0;
    end else begin
      hs1 <= hs0;
      vs1 <= vs0;
      de1 <= de0;
      x1  <= h0;
      y1  <= v0;
      if (h0 == '0) begin
        bar_pos <= '0;
        bar_idx <= '0;
      end else if (bar_pos == BAR_LAST) begin
        bar_pos <= '0;
        bar_idx <= (bar_idx == 3'd7) ? bar_idx : bar_idx + 3'd1;
      end else begin
        bar_pos <= bar_pos + 10'd1;
      end
    end
  end

  // Noise source: one step per visible pixel
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) lfsr <= LFSR_SEED;
    else if (de1) lfsr <= lfsr_next(lfsr);
  end

  // Config: last write wins; the pending word commits only on frame_end.
  // A write landing on frame_end stays pending while the older word commits.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cfg_pend    <= CFG_RESET;
      cfg_act     <= CFG_RESET;
      pend        <= 1'b0;
      cfg_applied <= 1'b0;
    end else begin
      cfg_applied <= frame_end && pend;
      if (frame_end && pend) cfg_act <= cfg_pend;
      if (cfg_valid) begin
        cfg_pend <= cfg_in;
        pend     <= 1'b1;
      end else if (frame_end) begin
        pend <= 1'b0;
      end
    end
  end

  // Stage 2 colour from stage-1 position, glyph input and active config
  always_comb begin
    col     = '0;
    fg_c    = cfg_act.fg[CW-1:0];
    bg_c    = cfg_act.bg[CW-1:0];
    bar_c   = {{COLOR_BITS{bar_idx[2]}}, {COLOR_BITS{bar_idx[1]}}, {COLOR_BITS{bar_idx[0]}}};
    shift_c = (cfg_act.shift > 4'd9) ? 4'd9 : cfg_act.shift;
    case (cfg_act.mode)
      MODE_NOISE:   col = lfsr[CW-1:0];
      MODE_GLYPH:   col = glyph_bit ? fg_c : bg_c;
      MODE_BARS:    col = bar_c;
      MODE_CHECKER: col = (x1[shift_c] ^ y1[shift_c]) ? fg_c : bg_c;
      default:      col = fg_c;
    endcase
  end

  // Stage 2: register all outputs together; blanking forces black
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hs  <= ~SYNC_ACTIVE;
      vs  <= ~SYNC_ACTIVE;
      de  <= 1'b0;
      rgb <= '0;
    end else begin
      hs  <= hs1;
      vs  <= vs1;
      de  <= de1;
      rgb <= de1 ? col : '0;
    end
  end

endmodule

// File: tb/tb_vga_pixel_engine.sv
// Self-checking bench for vga_pixel_engine on a small raster (16x4 active).
module tb_vga_pixel_engine;

  localparam int HA = 16, HFP = 2, HSW = 2, HBP = 2;
  localparam int VA = 4,  VFP = 1, VSW = 1, VBP = 1;
  localparam int HT = HA + HFP + HSW + HBP;   // 22
  localparam int VT = VA + VFP + VSW + VBP;   // 7
  localparam int FRAME = HT * VT;             // 154

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] cfg_data;
  logic        cfg_valid;
  logic        glyph_bit;
  logic [9:0]  px_x, px_y;
  logic        hs, vs, de, frame_end, cfg_applied;
  logic [5:0]  rgb;

  vga_pixel_engine #(
    .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HSW), .H_BP(HBP),
    .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VSW), .V_BP(VBP),
    .COLOR_BITS(2), .SYNC_ACTIVE(1'b0), .LFSR_SEED(16'hACE1)
  ) dut (
    .clk(clk), .rst_n(rst_n), .cfg_data(cfg_data), .cfg_valid(cfg_valid),
    .glyph_bit(glyph_bit), .px_x(px_x), .px_y(px_y), .hs(hs), .vs(vs),
    .rgb(rgb), .de(de), .frame_end(frame_end), .cfg_applied(cfg_applied)
  );

  always #5 clk = ~clk;

  int pass_cnt = 0;
  int chk_cnt  = 0;

  // Reference model state
  int          cnt;        // edges since reset release = stage-0 raster index
  int          e_q;        // raster index the outputs currently show (-1: none)
  logic [15:0] m_lfsr;
  logic [31:0] m_act, m_pend;
  bit          m_pend_v;
  logic        e_hs, e_vs, e_de, e_fa;
  logic [5:0]  e_rgb;
  bit          gpol;       // 0: glyph = px_x[0] of previous cycle, 1: random

  typedef struct {
    logic [31:0] cfg;
    int          x;
    int          y;
    logic [5:0]  exp;
  } vec_t;
  vec_t vt[20];

  function automatic int hp(input int p); return p % HT; endfunction
  function automatic int vp(input int p); return (p / HT) % VT; endfunction
  function automatic bit fe_at(input int p); return hp(p) == 0 && vp(p) == VA; endfunction
  function automatic logic de_at(input int p); return hp(p) < HA && vp(p) < VA; endfunction
  function automatic logic hs_at(input int p);
    return !(hp(p) >= HA + HFP && hp(p) < HA + HFP + HSW);
  endfunction
  function automatic logic vs_at(input int p);
    return !(vp(p) >= VA + VFP && vp(p) < VA + VFP + VSW);
  endfunction

  function automatic logic [31:0] mk(input int mode, input int fg, input int bg, input int sh);
    return 32'((mode & 7) << 29) | 32'((fg & 'hFFF) << 16) | 32'((bg & 'hFFF) << 4) | 32'(sh & 15);
  endfunction

  // Polynomial step: divide by x, fold x^16 back in as x^14+x^13+x^11+1
  function automatic logic [15:0] lfsr_adv(input logic [15:0] s);
    logic [15:0] r;
    r = s >> 1;
    if (s[0]) r = r ^ 16'hB400;
    return r;
  endfunction

  function automatic logic [5:0] model_colour(input int q, input logic g,
                                              input logic [31:0] cfg, input logic [15:0] l);
    int x, y, mode, s, b;
    logic [5:0] fg, bg;
    x = hp(q); y = vp(q);
    mode = int'(cfg >> 29);
    fg = 6'(cfg >> 16);
    bg = 6'(cfg >> 4);
    s = int'(cfg & 15);
    if (s > 9) s = 9;
    case (mode)
      0: return l[5:0];
      2: return g ? fg : bg;
      3: begin
        b = x / (HA / 8);
        if (b > 7) b = 7;
        return 6'((((b >> 2) & 1) * 48) + (((b >> 1) & 1) * 12) + ((b & 1) * 3));
      end
      4: return ((((x >> s) ^ (y >> s)) & 1) != 0) ? fg : bg;
      default: return fg;
    endcase
  endfunction

  function automatic logic [31:0] pk(input logic h_, input logic v_, input logic d_,
                                     input logic [5:0] c_, input logic f_, input logic a_,
                                     input logic [9:0] x_, input logic [9:0] y_);
    return {1'b0, h_, v_, d_, c_, f_, a_, x_, y_};
  endfunction

  task automatic check(input string nm, input logic [31:0] got, input logic [31:0] exp);
    chk_cnt++;
    if (got === exp) pass_cnt++;
    else $display("FAIL %s t=%0t got=%h want=%h", nm, $time, got, exp);
  endtask

  task automatic timeout(input string nm);
    chk_cnt++;
    $display("FAIL %s t=%0t got=timeout want=event", nm, $time);
  endtask

  task automatic model_reset();
    cnt = 0; e_q = -1;
    m_lfsr = 16'hACE1;
    m_act = mk(2, 'hFFF, 0, 0);
    m_pend = '0; m_pend_v = 0;
    e_hs = 1; e_vs = 1; e_de = 0; e_rgb = '0; e_fa = 0;
  endtask

  // Advance the model by one clock edge using the inputs held during that cycle
  task automatic model_step();
    bit fe;
    fe = fe_at(cnt);
    if (cnt == 0) begin
      e_q = -1; e_hs = 1; e_vs = 1; e_de = 0; e_rgb = '0;
    end else begin
      e_q = cnt - 1;
      e_hs = hs_at(e_q); e_vs = vs_at(e_q); e_de = de_at(e_q);
      e_rgb = e_de ? model_colour(e_q, glyph_bit, m_act, m_lfsr) : 6'h00;
      if (e_de) m_lfsr = lfsr_adv(m_lfsr);
    end
    e_fa = fe && m_pend_v;
    if (fe && m_pend_v) begin
      m_act = m_pend;
      m_pend_v = 0;
    end
    if (cfg_valid) begin
      m_pend = cfg_data;
      m_pend_v = 1;
    end
    cnt++;
  endtask

  task automatic cycle();
    @(posedge clk);
    model_step();
    @(negedge clk);
    check("pipe", pk(hs, vs, de, rgb, frame_end, cfg_applied, px_x, px_y),
          pk(e_hs, e_vs, e_de, e_rgb, fe_at(cnt), e_fa, 10'(hp(cnt)), 10'(vp(cnt))));
    cfg_valid = 1'b0;
    glyph_bit = gpol ? 1'($urandom_range(0, 1)) : 1'(hp(cnt - 1) & 1);
  endtask

  task automatic wr(input logic [31:0] w);
    cfg_data = w;
    cfg_valid = 1'b1;
    cycle();
  endtask

  task automatic wait_applied();
    bit ok;
    ok = 0;
    for (int i = 0; i < 3 * FRAME; i++) begin
      cycle();
      if (e_fa) begin ok = 1; break; end
    end
    if (ok) check("cfg_applied", 32'(cfg_applied), 32'd1);
    else timeout("wait_applied");
  endtask

  task automatic wait_pos(input int x, input int y);
    bit ok;
    ok = 0;
    for (int i = 0; i < 2 * FRAME; i++) begin
      cycle();
      if (e_q >= 0 && hp(e_q) == x && vp(e_q) == y) begin ok = 1; break; end
    end
    if (!ok) timeout("wait_pos");
  endtask

  task automatic run_to(input int x, input int y);
    bit ok;
    ok = 0;
    for (int i = 0; i < 2 * FRAME; i++) begin
      if (hp(cnt) == x && vp(cnt) == y) begin ok = 1; break; end
      cycle();
    end
    if (!ok) timeout("run_to");
  endtask

  initial begin
    int n_hs, n_vs, n_de;
    bit ok;

    vt[0]  = '{mk(1, 'h2A, 'h15, 0), 3, 1, 6'h2A};
    vt[1]  = '{mk(2, 'h2A, 'h15, 0), 3, 1, 6'h2A};
    vt[2]  = '{mk(2, 'h2A, 'h15, 0), 4, 1, 6'h15};
    vt[3]  = '{mk(3, 0, 0, 0),       0, 2, 6'h00};
    vt[4]  = '{mk(3, 0, 0, 0),       2, 2, 6'h03};
    vt[5]  = '{mk(3, 0, 0, 0),       5, 2, 6'h0C};
    vt[6]  = '{mk(3, 0, 0, 0),       7, 2, 6'h0F};
    vt[7]  = '{mk(3, 0, 0, 0),       8, 2, 6'h30};
    vt[8]  = '{mk(3, 0, 0, 0),      11, 2, 6'h33};
    vt[9]  = '{mk(3, 0, 0, 0),      12, 2, 6'h3C};
    vt[10] = '{mk(3, 0, 0, 0),      15, 2, 6'h3F};
    vt[11] = '{mk(4, 'h3F, 0, 0),    1, 0, 6'h3F};
    vt[12] = '{mk(4, 'h3F, 0, 0),    1, 1, 6'h00};
    vt[13] = '{mk(4, 'h3F, 0, 1),    2, 0, 6'h3F};
    vt[14] = '{mk(4, 'h3F, 0, 1),    2, 2, 6'h00};
    vt[15] = '{mk(4, 'h3F, 'h12, 15), 9, 3, 6'h12};
    vt[16] = '{mk(6, 'h21, 0, 0),    0, 0, 6'h21};
    vt[17] = '{mk(1, 'h2A, 0, 0),   18, 1, 6'h00};
    vt[18] = '{mk(1, 'hFEA, 0, 0),  10, 3, 6'h2A};
    vt[19] = '{mk(1, 'h2A, 0, 0),    5, 5, 6'h00};

    // Reset
    rst_n = 1'b0; cfg_valid = 1'b0; cfg_data = '0; glyph_bit = 1'b0; gpol = 0;
    repeat (3) @(negedge clk);
    check("reset_state", pk(hs, vs, de, rgb, frame_end, cfg_applied, px_x, px_y),
          pk(1, 1, 0, 6'h00, 0, 0, 10'd0, 10'd0));
    rst_n = 1'b1;
    model_reset();

    // Sync / enable duty over one whole frame
    gpol = 1;
    repeat (FRAME + 5) cycle();
    n_hs = 0; n_vs = 0; n_de = 0;
    for (int i = 0; i < FRAME; i++) begin
      cycle();
      if (hs == 1'b0) n_hs++;
      if (vs == 1'b0) n_vs++;
      if (de == 1'b1) n_de++;
    end
    check("hs_low_per_frame", 32'(n_hs), 32'(HSW * VT));
    check("vs_low_per_frame", 32'(n_vs), 32'(VSW * HT));
    check("de_per_frame",     32'(n_de), 32'(HA * VA));

    // Mid-frame solid write: no change until frame end
    run_to(4, 1);
    wr(mk(1, 'h2A, 0, 0));
    wait_applied();
    for (int i = 0; i < FRAME; i++) begin
      cycle();
      if (e_q >= 0) check("solid_px", 32'(rgb), de_at(e_q) ? 32'h2A : 32'h00);
    end

    // Glyph alternation driven from the previous px_x
    gpol = 0;
    wr(mk(2, 'h2A, 'h15, 0));
    wait_applied();
    for (int i = 0; i < FRAME; i++) begin
      cycle();
      if (e_q >= 0 && de_at(e_q))
        check("glyph_px", 32'(rgb), (hp(e_q) & 1) != 0 ? 32'h2A : 32'h15);
    end

    // Table of single-pixel expectations
    for (int k = 0; k < 20; k++) begin
      wr(vt[k].cfg);
      wait_applied();
      wait_pos(vt[k].x, vt[k].y);
      check($sformatf("vec%0d", k), 32'(rgb), 32'(vt[k].exp));
    end

    // Two writes, then a third on the frame_end cycle
    run_to(3, 1);
    wr(mk(1, 'h11, 0, 0));
    repeat (5) cycle();
    wr(mk(4, 'h3F, 'h05, 0));
    ok = 0;
    for (int i = 0; i < 2 * FRAME; i++) begin
      if (fe_at(cnt)) begin ok = 1; break; end
      cycle();
    end
    if (!ok) timeout("find_frame_end");
    check("fe_seen", 32'(frame_end), 32'd1);
    wr(mk(3, 0, 0, 0));
    check("coincident_apply", 32'(cfg_applied), 32'd1);
    wait_pos(1, 0);
    check("checker_after", 32'(rgb), 32'h3F);
    wait_pos(2, 0);
    check("checker_after2", 32'(rgb), 32'h05);
    wait_applied();
    wait_pos(3, 0);
    check("bars_next_frame", 32'(rgb), 32'h03);

    // Random configs, random glyph
    gpol = 1;
    wr(mk(0, 0, 0, 0));
    for (int i = 0; i < 8 * FRAME; i++) begin
      if ($urandom_range(0, 79) == 0)
        wr(mk($urandom_range(0, 7), int'($urandom), int'($urandom), $urandom_range(0, 15)));
      else
        cycle();
    end

    // Asynchronous reset mid-line
    run_to(7, 1);
    #2 rst_n = 1'b0;
    #1 check("async_reset", pk(hs, vs, de, rgb, frame_end, cfg_applied, px_x, px_y),
             pk(1, 1, 0, 6'h00, 0, 0, 10'd0, 10'd0));
    @(negedge clk);
    check("reset_hold", pk(hs, vs, de, rgb, frame_end, cfg_applied, px_x, px_y),
          pk(1, 1, 0, 6'h00, 0, 0, 10'd0, 10'd0));
    rst_n = 1'b1;
    model_reset();
    wr(mk(0, 0, 0, 0));
    wait_applied();
    wait_pos(0, 0);
    check("first_noise_px", 32'(rgb), 32'(e_rgb));
    repeat (2 * FRAME) cycle();

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
